// File: rtl/wallace_arb_pkg.sv
// Shared types and carry-save helpers for the arbitrated Wallace multiplier.
package wallace_arb_pkg;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef logic signed [OP_W-1:0]   op_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    function automatic logic [PROD_W-1:0] csa_s(input logic [PROD_W-1:0] a, b, c);
        return a ^ b ^ c;
    endfunction

    // Carry word is already shifted into its column weight.
    function automatic logic [PROD_W-1:0] csa_c(input logic [PROD_W-1:0] a, b, c);
        logic [PROD_W-1:0] m;
        m = (a & b) | (a & c) | (b & c);
        return {m[PROD_W-2:0], 1'b0};
    endfunction
endpackage

// File: rtl/wallace_rr_arbiter.sv
// Request arbiter: round-robin with WALLACE_ARB_RR_EN defined, otherwise
// fixed priority (lowest index wins, no pointer state, no clock).
module wallace_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
`ifdef WALLACE_ARB_RR_EN
    input  logic               clk,
    input  logic               reset_n,
`endif
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);
    logic w_found;

`ifdef WALLACE_ARB_RR_EN
    logic [ID_W-1:0] r_prio;

    // Scan starts at the pointer and wraps past the top index.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        grant_id = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(r_prio) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_prio <= '0;
        else if (|grant)
            r_prio <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end
`else
    always_comb begin
        w_found  = 1'b0;
        grant_id = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (req[i]) begin
                w_found  = 1'b1;
                grant_id = ID_W'(i);
            end
        end
    end
`endif

    assign grant = (enable && w_found) ? (NUM_REQ'(1) << grant_id) : '0;
endmodule

// File: rtl/wallace_tree_multiplier_8_bit.sv
// Combinational 8x8 signed multiplier: sign-extended partial products reduced
// by a four-level 3:2 carry-save tree and one final carry-propagate add.
module wallace_tree_multiplier_8_bit
    import wallace_arb_pkg::*;
(
    input  op_t   a,
    input  op_t   b,
    output prod_t p
);
    logic [PROD_W-1:0]      w_xs;
    logic [8:0][PROD_W-1:0] w_pp;
    logic [PROD_W-1:0]      w_s1a, w_c1a, w_s1b, w_c1b, w_s1c, w_c1c;
    logic [PROD_W-1:0]      w_s2a, w_c2a, w_s2b, w_c2b, w_s3, w_c3, w_s4, w_c4;

    assign w_xs = {{(PROD_W-OP_W){a[OP_W-1]}}, a};

    // The MSB of b carries weight -2^7: subtract via ones-complement plus a +1 row.
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < OP_W-1; i++)
            w_pp[i] = b[i] ? (w_xs << i) : '0;
        w_pp[7] = b[OP_W-1] ? ~(w_xs << (OP_W-1)) : '0;
        w_pp[8] = {{(PROD_W-1){1'b0}}, b[OP_W-1]};
    end

    assign w_s1a = csa_s(w_pp[0], w_pp[1], w_pp[2]);
    assign w_c1a = csa_c(w_pp[0], w_pp[1], w_pp[2]);
    assign w_s1b = csa_s(w_pp[3], w_pp[4], w_pp[5]);
    assign w_c1b = csa_c(w_pp[3], w_pp[4], w_pp[5]);
    assign w_s1c = csa_s(w_pp[6], w_pp[7], w_pp[8]);
    assign w_c1c = csa_c(w_pp[6], w_pp[7], w_pp[8]);

    assign w_s2a = csa_s(w_s1a, w_c1a, w_s1b);
    assign w_c2a = csa_c(w_s1a, w_c1a, w_s1b);
    assign w_s2b = csa_s(w_c1b, w_s1c, w_c1c);
    assign w_c2b = csa_c(w_c1b, w_s1c, w_c1c);

    assign w_s3  = csa_s(w_s2a, w_c2a, w_s2b);
    assign w_c3  = csa_c(w_s2a, w_c2a, w_s2b);
    assign w_s4  = csa_s(w_s3, w_c3, w_c2b);
    assign w_c4  = csa_c(w_s3, w_c3, w_c2b);

    assign p = w_s4 + w_c4;
endmodule

// File: rtl/wallace_mult_arbiter.sv
// NUM_REQ requesters share one Wallace multiplier through a two-stage
// valid/ready pipeline. WALLACE_ARB_RR_EN selects round-robin arbitration.
module wallace_mult_arbiter
    import wallace_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][OP_W-1:0]  req_x,
    input  logic [NUM_REQ-1:0][OP_W-1:0]  req_y,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output prod_t                         resp_z
);
    logic            r_s1_valid;
    op_t             r_s1_x, r_s1_y;
    logic [ID_W-1:0] r_s1_id;

    logic            w_s2_load, w_s1_free, w_accept;
    logic [ID_W-1:0] w_gid;
    prod_t           w_prod;

    assign w_s2_load = r_s1_valid & (~resp_valid | resp_ready);
    assign w_s1_free = ~r_s1_valid | w_s2_load;
    assign w_accept  = |req_ready;

    wallace_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
`ifdef WALLACE_ARB_RR_EN
        .clk      (clk),
        .reset_n  (reset_n),
`endif
        .req      (req_valid),
        .enable   (w_s1_free),
        .grant    (req_ready),
        .grant_id (w_gid)
    );

    wallace_tree_multiplier_8_bit u_mul (
        .a (r_s1_x),
        .b (r_s1_y),
        .p (w_prod)
    );

    // An accept refills stage 1 even when stage 1 drains on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_id    <= '0;
            resp_valid <= 1'b0;
            resp_z     <= '0;
            resp_id    <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_x     <= req_x[w_gid];
                r_s1_y     <= req_y[w_gid];
                r_s1_id    <= w_gid;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_load) begin
                resp_valid <= 1'b1;
                resp_z     <= w_prod;
                resp_id    <= r_s1_id;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// Scoreboard bench for wallace_mult_arbiter: queued requesters, accept-time
// expectations, and a negedge monitor comparing every delivered product.
module tb_wallace_mult_arbiter;
    localparam int N = 4;

    typedef struct packed { logic [7:0] x; logic [7:0] y; } op_pair_t;
    typedef struct { int id; int z; } exp_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [N-1:0]        req_valid;
    logic [N-1:0][7:0]   req_x, req_y;
    logic [N-1:0]        req_ready;
    logic                resp_valid, resp_ready;
    logic [1:0]          resp_id;
    logic signed [15:0]  resp_z;

    op_pair_t rq[N][$];
    exp_t     sb[$];
    int       hid[$], hz[$], hcyc[$];
    int       checks = 0, errors = 0, cyc = 0;
    logic [N-1:0] acc = '0;
    logic     rr_rand = 1'b0;

    always #5 clk = ~clk;

    wallace_mult_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_x(req_x),
        .req_y(req_y), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_id(resp_id), .resp_z(resp_z)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input int x, input int y);
        op_pair_t p;
        p.x = 8'(x);
        p.y = 8'(y);
        rq[i].push_back(p);
    endtask

    function automatic bit busy();
        for (int i = 0; i < N; i++)
            if (rq[i].size() != 0) return 1'b1;
        return (sb.size() != 0) || resp_valid;
    endfunction

    task automatic drain(input int max);
        int n = 0;
        while (busy() && n < max) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", int'(busy()), 0);
    endtask

    task automatic clr_hist();
        hid.delete(); hz.delete(); hcyc.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rr_rand = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        sb.delete();
        acc = '0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    always @(posedge clk) cyc++;

    // Requester model: present queue heads, retire accepted ones.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        acc = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (rq[i].size() != 0);
            if (rq[i].size() != 0) begin
                req_x[i] = rq[i][0].x;
                req_y[i] = rq[i][0].y;
            end
        end
        if (rr_rand) resp_ready = ($urandom_range(0, 7) != 0);
    end

    // Accept observer pushes expectations; monitor pops on each handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    int ex, ey;
                    ex = int'($signed(req_x[i]));
                    ey = int'($signed(req_y[i]));
                    e.id = i;
                    e.z  = ex * ey;
                    acc[i] = 1'b1;
                    sb.push_back(e);
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_id", int'(resp_id), e.id);
                    chk("resp_z", int'(resp_z), e.z);
                end
                hid.push_back(int'(resp_id));
                hz.push_back(int'(resp_z));
                hcyc.push_back(cyc);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ids[12];
        req_valid = '0; req_x = '0; req_y = '0; resp_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_z", int'(resp_z), 0);
        chk("rst_resp_id", int'(resp_id), 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", int'(req_ready), 0);

        // Single request, latency
        push(2, -74, -99);
        @(posedge clk); @(negedge clk);
        chk("single_grant", int'(req_ready), 4'b0100);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("single_valid", int'(resp_valid), 1);
        chk("single_z", int'(resp_z), 7326);
        chk("single_id", int'(resp_id), 2);
        drain(20);

        // Extreme operands
        clr_hist();
        push(0, -128, -128); push(0, -128, 127); push(0, 0, -1);
        drain(30);
        chk("ext_count", hz.size(), 3);
        if (hz.size() >= 3) begin
            chk("ext_z0", hz[0], 16384);
            chk("ext_z1", hz[1], -16256);
            chk("ext_z2", hz[2], 0);
        end

        // All four continuously valid
        do_reset();
        clr_hist();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N; i++) push(i, 10*i + k + 1, -3 - k);
        for (int j = 0; j < 12; j++)
`ifdef WALLACE_ARB_RR_EN
            exp_ids[j] = j % 4;
`else
            exp_ids[j] = j / 3;
`endif
        drain(60);
        chk("all4_count", hid.size(), 12);
        if (hid.size() >= 12)
            for (int j = 0; j < 12; j++) begin
                chk("all4_order", hid[j], exp_ids[j]);
                chk("all4_b2b", hcyc[j] - hcyc[0], j);
            end

        // Backpressure
        do_reset();
        resp_ready = 1'b0;
        clr_hist();
        push(0, 5, 7); push(0, -3, 11); push(1, 100, -2);
        repeat (3) @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", int'(resp_valid), 1);
            chk("bp_z_hold", int'(resp_z), 35);
            chk("bp_id_hold", int'(resp_id), 0);
            chk("bp_no_grant", int'(req_ready), 0);
        end
        @(posedge clk);
        #2 resp_ready = 1'b1;
        drain(40);
        chk("bp_count", hz.size(), 3);
        if (hz.size() >= 3) begin
            chk("bp_z0", hz[0], 35);
`ifdef WALLACE_ARB_RR_EN
            chk("bp_z1", hz[1], -200);
            chk("bp_z2", hz[2], -33);
`else
            chk("bp_z1", hz[1], -33);
            chk("bp_z2", hz[2], -200);
`endif
            chk("bp_b2b", hcyc[1] - hcyc[0], 1);
        end

        // Reset mid-flight
        do_reset();
        resp_ready = 1'b0;
        push(0, 9, 9); push(0, 2, 3); push(0, 4, 4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_full", int'(resp_valid), 1);
        #1 reset_n = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        sb.delete();
        acc = '0;
        #1 chk("mid_async_drop", int'(resp_valid), 0);
        clr_hist();
        resp_ready = 1'b1;
        push(3, 12, 12); push(1, 6, -7);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        chk("mid_first_grant", int'(req_ready), 4'b0010);
        drain(30);
        chk("mid_count", hid.size(), 2);
        if (hid.size() >= 2) begin
            chk("mid_id0", hid[0], 1);
            chk("mid_z0", hz[0], -42);
            chk("mid_id1", hid[1], 3);
            chk("mid_z1", hz[1], 144);
        end

        // Sweep: every x, every y value covered, random requesters and ready
        do_reset();
        rr_rand = 1'b1;
        for (int xi = 0; xi < 256; xi++)
            for (int k = 0; k < 64; k++)
                push($urandom_range(0, N-1), xi, 4*k + (xi & 3));
        drain(40000);
        rr_rand = 1'b0;
        resp_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
